dtc_pulse_gen: RTL and testbench

Digital-to-time pulse generator: the transmit-side counterpart of the trigger-interval measurement block. It accepts an 8-bit code over a valid/ready handshake and, once per fixed-length frame, drives `pulse_out` low for exactly that many `clk` cycles. This produces a falling-edge-to-rising-edge interval the measurement side can capture. It also issues a one-cycle frame marker per frame so the analog front end and the measurement side share frame alignment.

---
 rtl/dtc_pulse_gen.sv | 92 +++++++++
 tb/tb_dtc_pulse_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dtc_pulse_gen.sv
// dtc_pulse_gen: digital-to-time pulse generator, one low phase of programmable width per frame.
//   Optional macro DTC_REPEAT_EN: a frame with no new code re-emits the previous low width.
//   clk         : sole clock, all logic on posedge
//   rst         : asynchronous active-high reset
//   code_in     : requested low-phase length in cycles (clamped to LOW_MAX)
//   code_valid  : code_in offered; transfer when code_valid && code_ready
//   code_ready  : holding register empty
//   pulse_out   : generated waveform, idle high, low for 'active' cycles per frame
//   frame_pulse : one-cycle marker at frame start (fcnt == 0)
//   underrun    : one-cycle flag, frame started with no new code
//   sat         : one-cycle flag, accepted code was clamped
module dtc_pulse_gen #(
    parameter int WIDTH  = 8,
    parameter int PERIOD = 251,
    parameter int GUARD  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] code_in,
    input  logic             code_valid,
    output logic             code_ready,
    output logic             pulse_out,
    output logic             frame_pulse,
    output logic             underrun,
    output logic             sat
);
    localparam int CW      = $clog2(PERIOD);
    localparam int LOW_MAX = ((2 ** WIDTH) - 1 < PERIOD - GUARD - 1) ? (2 ** WIDTH) - 1 : PERIOD - GUARD - 1;

    // LOW_S is the only encoding with both bits clear, so the decode below is glitch-free.
    typedef enum logic [1:0] {LOW_S = 2'b00, GUARD_S = 2'b01, HIGH_S = 2'b11} state_t;

    logic [CW-1:0]    r_fcnt;
    logic [WIDTH-1:0] r_hold;
    logic             r_full;
    logic [WIDTH-1:0] r_active;
    state_t           r_state;
    logic             r_frame;
    logic             r_under;
    logic             r_sat;

    logic             w_bnd;
    logic             w_acc;
    logic [CW-1:0]    w_fcnt_n;
    logic [WIDTH-1:0] w_hold_n;
    logic [WIDTH-1:0] w_active_n;
    state_t           w_state_n;

    always_comb begin
        w_bnd      = r_fcnt == CW'(PERIOD - 1);
        w_acc      = code_valid && !r_full;
        w_fcnt_n   = w_bnd ? '0 : r_fcnt + 1'b1;
        w_hold_n   = (code_in > WIDTH'(LOW_MAX)) ? WIDTH'(LOW_MAX) : code_in;
`ifdef DTC_REPEAT_EN
        w_active_n = w_bnd ? (r_full ? r_hold : r_active) : r_active;
`else
        w_active_n = w_bnd ? (r_full ? r_hold : '0) : r_active;
`endif
        // State is computed for the cycle after this edge so pulse_out comes straight off a flop.
        w_state_n  = (int'(w_fcnt_n) < GUARD) ? GUARD_S :
                     (int'(w_fcnt_n) < GUARD + int'(w_active_n)) ? LOW_S : HIGH_S;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcnt   <= CW'(PERIOD - 1);
            r_hold   <= '0;
            r_full   <= 1'b0;
            r_active <= '0;
            r_state  <= HIGH_S;
            r_frame  <= 1'b0;
            r_under  <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            r_fcnt   <= w_fcnt_n;
            r_hold   <= w_acc ? w_hold_n : r_hold;
            // Accept cannot coincide with a boundary that drains a full register.
            r_full   <= w_acc || (r_full && !w_bnd);
            r_active <= w_active_n;
            r_state  <= w_state_n;
            r_frame  <= w_bnd;
            r_under  <= w_bnd && !r_full;
            r_sat    <= w_acc && (code_in > WIDTH'(LOW_MAX));
        end
    end

    assign code_ready  = !r_full;
    assign pulse_out   = r_state != LOW_S;
    assign frame_pulse = r_frame;
    assign underrun    = r_under;
    assign sat         = r_sat;
endmodule

// File: tb/tb_dtc_pulse_gen.sv
// tb_dtc_pulse_gen: directed self-checking bench for dtc_pulse_gen at default parameters.
module tb_dtc_pulse_gen;
    localparam int P = 251;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] code_in = '0;
    logic       code_valid = 1'b0;
    logic       code_ready, pulse_out, frame_pulse, underrun, sat;

    int checks = 0;
    int failures = 0;
    bit [P-1:0] sp, sr, sf, su, ss;
    bit [P-1:0] one = 1;
    int n_low, f_low, l_low;
    bit fp_ok;

    dtc_pulse_gen dut (
        .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
        .code_ready(code_ready), .pulse_out(pulse_out), .frame_pulse(frame_pulse),
        .underrun(underrun), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic wait_fp();
        fp_ok = 1'b0;
        for (int k = 0; k < P + 5 && !fp_ok; k++) begin
            @(negedge clk);
            fp_ok = frame_pulse;
        end
        checks++;
        if (!fp_ok) begin failures++; $display("FAIL frame_pulse_timeout got=0 exp=1"); end
    endtask

    // Records one whole frame (index = fcnt) while driving code_valid over [vf,vt]; code c1 before sw, c2 from sw.
    task automatic frame(input int vf, input int vt, input logic [7:0] c1, input int sw, input logic [7:0] c2);
        wait_fp();
        n_low = 0; f_low = -1; l_low = -1;
        for (int i = 0; i < P; i++) begin
            if (i > 0) @(negedge clk);
            sp[i] = pulse_out; sr[i] = code_ready; sf[i] = frame_pulse; su[i] = underrun; ss[i] = sat;
            if (!pulse_out) begin n_low++; if (f_low < 0) f_low = i; l_low = i; end
            code_valid = (i >= vf && i <= vt);
            code_in = (i < sw) ? c1 : c2;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (pulse_out !== 1'b1) begin failures++; $display("FAIL rst_pulse_out got=%b exp=1", pulse_out); end
        checks++; if (code_ready !== 1'b1) begin failures++; $display("FAIL rst_code_ready got=%b exp=1", code_ready); end
        checks++; if (frame_pulse !== 1'b0) begin failures++; $display("FAIL rst_frame_pulse got=%b exp=0", frame_pulse); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL rst_sat got=%b exp=0", sat); end
        code_valid = 1'b1; code_in = 8'd10;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        frame(1, 0, 0, 999, 0);
        checks++; if (sf !== one) begin failures++; $display("FAIL first_frame_pulse got=%0h exp=%0h", sf, one); end
        checks++; if (su !== one) begin failures++; $display("FAIL first_underrun got=%0h exp=%0h", su, one); end
        checks++; if (n_low !== 0) begin failures++; $display("FAIL first_low_width got=%0d exp=0", n_low); end
        checks++; if (sr[0] !== 1'b0) begin failures++; $display("FAIL first_ready_full got=%b exp=0", sr[0]); end
        frame(100, 100, 0, 999, 0);
        checks++; if (n_low !== 10) begin failures++; $display("FAIL basic_low_width got=%0d exp=10", n_low); end
        checks++; if (f_low !== 2) begin failures++; $display("FAIL basic_low_first got=%0d exp=2", f_low); end
        checks++; if (l_low !== 11) begin failures++; $display("FAIL basic_low_last got=%0d exp=11", l_low); end
        checks++; if (su !== '0) begin failures++; $display("FAIL basic_underrun got=%0h exp=0", su); end
        checks++; if (sf !== one) begin failures++; $display("FAIL basic_frame_pulse got=%0h exp=%0h", sf, one); end
    endtask

    task automatic test_zero();
        frame(50, 50, 255, 999, 0);
        checks++; if (n_low !== 0) begin failures++; $display("FAIL zero_low_width got=%0d exp=0", n_low); end
        checks++; if (su !== '0) begin failures++; $display("FAIL zero_underrun got=%0h exp=0", su); end
        checks++; if (sr[0] !== 1'b1) begin failures++; $display("FAIL zero_ready_after_bnd got=%b exp=1", sr[0]); end
        checks++; if (ss !== (one << 51)) begin failures++; $display("FAIL sat_pulse got=%0h exp=%0h", ss, one << 51); end
    endtask

    task automatic test_sat();
        frame(10, 10, 20, 999, 0);
        checks++; if (n_low !== 248) begin failures++; $display("FAIL sat_low_width got=%0d exp=248", n_low); end
        checks++; if (f_low !== 2) begin failures++; $display("FAIL sat_low_first got=%0d exp=2", f_low); end
        checks++; if (l_low !== 249) begin failures++; $display("FAIL sat_low_last got=%0d exp=249", l_low); end
        checks++; if (sp[250] !== 1'b1) begin failures++; $display("FAIL sat_high_250 got=%b exp=1", sp[250]); end
        checks++; if (ss !== '0) begin failures++; $display("FAIL sat_no_clamp got=%0h exp=0", ss); end
    endtask

    task automatic test_underrun();
        int exp_low;
`ifdef DTC_REPEAT_EN
        exp_low = 20;
`else
        exp_low = 0;
`endif
        frame(1, 0, 0, 999, 0);
        checks++; if (n_low !== 20) begin failures++; $display("FAIL code20_low_width got=%0d exp=20", n_low); end
        checks++; if (l_low !== 21) begin failures++; $display("FAIL code20_low_last got=%0d exp=21", l_low); end
        frame(200, 250, 5, 201, 7);
        checks++; if (su !== one) begin failures++; $display("FAIL underrun_flag got=%0h exp=%0h", su, one); end
        checks++; if (sf !== one) begin failures++; $display("FAIL underrun_frame_pulse got=%0h exp=%0h", sf, one); end
        checks++; if (n_low !== exp_low) begin failures++; $display("FAIL underrun_low_width got=%0d exp=%0d", n_low, exp_low); end
    endtask

    task automatic test_back_to_back();
        checks++; if (sr[200] !== 1'b1) begin failures++; $display("FAIL b2b_ready_first got=%b exp=1", sr[200]); end
        checks++; if (sr[250] !== 1'b0) begin failures++; $display("FAIL b2b_ready_held got=%b exp=0", sr[250]); end
        frame(0, 0, 7, 999, 7);
        checks++; if (sr[0] !== 1'b1) begin failures++; $display("FAIL b2b_ready_bnd got=%b exp=1", sr[0]); end
        checks++; if (sr[1] !== 1'b0) begin failures++; $display("FAIL b2b_second_accept got=%b exp=0", sr[1]); end
        checks++; if (n_low !== 5) begin failures++; $display("FAIL b2b_width5 got=%0d exp=5", n_low); end
        checks++; if (l_low !== 6) begin failures++; $display("FAIL b2b_last5 got=%0d exp=6", l_low); end
        frame(20, 20, 100, 999, 0);
        checks++; if (n_low !== 7) begin failures++; $display("FAIL b2b_width7 got=%0d exp=7", n_low); end
        checks++; if (su !== '0) begin failures++; $display("FAIL b2b_underrun got=%0h exp=0", su); end
    endtask

    task automatic test_async_reset();
        wait_fp();
        repeat (10) @(negedge clk);
        code_valid = 1'b1; code_in = 8'd30;
        @(negedge clk);
        code_valid = 1'b0;
        repeat (39) @(negedge clk);
        checks++; if (pulse_out !== 1'b0) begin failures++; $display("FAIL arst_pre_low got=%b exp=0", pulse_out); end
        checks++; if (code_ready !== 1'b0) begin failures++; $display("FAIL arst_pre_full got=%b exp=0", code_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (pulse_out !== 1'b1) begin failures++; $display("FAIL arst_pulse_out got=%b exp=1", pulse_out); end
        checks++; if (code_ready !== 1'b1) begin failures++; $display("FAIL arst_code_ready got=%b exp=1", code_ready); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        frame(1, 0, 0, 999, 0);
        checks++; if (sf !== one) begin failures++; $display("FAIL arst_frame_pulse got=%0h exp=%0h", sf, one); end
        checks++; if (su !== one) begin failures++; $display("FAIL arst_underrun got=%0h exp=%0h", su, one); end
        checks++; if (n_low !== 0) begin failures++; $display("FAIL arst_low_width got=%0d exp=0", n_low); end
        frame(1, 0, 0, 999, 0);
        checks++; if (su !== one) begin failures++; $display("FAIL arst_hold_discarded got=%0h exp=%0h", su, one); end
        checks++; if (n_low !== 0) begin failures++; $display("FAIL arst_second_low got=%0d exp=0", n_low); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_sat();
        test_underrun();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
